// File: rtl/gc_pkg.sv
// Shared types and constants for the gate-control scheduler.
// Contents: FSM state enum, queue index constants, credit/length widths and
// a one-hot helper that turns a queue index into a read-enable vector.
package gc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } gc_state_e;

  localparam int unsigned Q_TSN_EVEN = 0;
  localparam int unsigned Q_TSN_ODD  = 1;
  localparam int unsigned Q_RSV      = 2;
  localparam int unsigned Q_BE       = 3;

  localparam int unsigned CREDIT_W = 20;
  localparam int unsigned LEN_W    = 11;

  typedef logic [1:0] gc_qidx_t;

  function automatic logic [3:0] gc_onehot(input gc_qidx_t q);
    gc_onehot = 4'b0001 << q;
  endfunction

endpackage

// File: rtl/gc_sched_if.sv
// Bus between the metadata buffer / transmitter and the gate-control scheduler.
// Signals:
//   in_gc_fifo_empty[3:0]  per-queue empty flags (q0..q3)
//   in_gc_pkt_len[10:0]    q2 head length in bytes
//   in_gc_idle_slope[15:0] q2 credit added per cycle
//   in_gc_gate_en          global grant enable
//   in_gc_slot_sync        slot restart pulse
//   in_gc_tx_done          transmitter completion pulse
//   out_gc_q_rden[3:0]     one-hot read pulse
//   out_gc_slot_parity     0 even / 1 odd slot
//   out_gc_busy            GRANT or WAIT
//   out_gc_credit[19:0]    signed q2 credit
//   out_gc_timeout_err     sticky transmit timeout flag
// master = driver of the in_* signals, slave = the scheduler.
interface gc_sched_if;

  logic [3:0]                   in_gc_fifo_empty;
  logic [gc_pkg::LEN_W-1:0]     in_gc_pkt_len;
  logic [15:0]                  in_gc_idle_slope;
  logic                         in_gc_gate_en;
  logic                         in_gc_slot_sync;
  logic                         in_gc_tx_done;
  logic [3:0]                   out_gc_q_rden;
  logic                         out_gc_slot_parity;
  logic                         out_gc_busy;
  logic [gc_pkg::CREDIT_W-1:0]  out_gc_credit;
  logic                         out_gc_timeout_err;

  modport master (
    output in_gc_fifo_empty, in_gc_pkt_len, in_gc_idle_slope,
           in_gc_gate_en, in_gc_slot_sync, in_gc_tx_done,
    input  out_gc_q_rden, out_gc_slot_parity, out_gc_busy,
           out_gc_credit, out_gc_timeout_err
  );

  modport slave (
    input  in_gc_fifo_empty, in_gc_pkt_len, in_gc_idle_slope,
           in_gc_gate_en, in_gc_slot_sync, in_gc_tx_done,
    output out_gc_q_rden, out_gc_slot_parity, out_gc_busy,
           out_gc_credit, out_gc_timeout_err
  );

endinterface

// File: rtl/gc_cbs_credit.sv
// Credit-based shaper state for the reservation/PTP queue (q2).
// Ports:
//   clk, rst       clock, async active-high reset (credit -> 0)
//   i_grant_q2     q2 read pulse this cycle; debit the latched length
//   i_q2_empty     q2 empty flag
//   i_pkt_len      length latched at the grant decision
//   i_idle_slope   unsigned credit added per cycle
//   o_credit       signed credit, saturating at -2^19 and CREDIT_MAX
module gc_cbs_credit
  import gc_pkg::*;
#(
  parameter logic signed [CREDIT_W-1:0] CREDIT_MAX = 20'sd65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_grant_q2,
  input  logic                       i_q2_empty,
  input  logic [LEN_W-1:0]           i_pkt_len,
  input  logic [15:0]                i_idle_slope,
  output logic signed [CREDIT_W-1:0] o_credit
);

  // One guard bit is enough: |slope|, |len| and |credit| all fit in CREDIT_W bits.
  localparam logic signed [CREDIT_W:0] W_MAX = $signed({CREDIT_MAX[CREDIT_W-1], CREDIT_MAX});
  localparam logic signed [CREDIT_W:0] W_MIN = $signed({2'b11, {(CREDIT_W-1){1'b0}}});

  logic signed [CREDIT_W-1:0] r_credit;
  logic signed [CREDIT_W:0]   w_ext;
  logic signed [CREDIT_W:0]   w_len;
  logic signed [CREDIT_W:0]   w_slope;
  logic signed [CREDIT_W:0]   w_sum;
  logic signed [CREDIT_W-1:0] w_next;

  assign w_ext   = {r_credit[CREDIT_W-1], r_credit};
  assign w_len   = {{(CREDIT_W+1-LEN_W){1'b0}}, i_pkt_len};
  assign w_slope = {{(CREDIT_W+1-16){1'b0}}, i_idle_slope};

  always_comb begin
    w_sum = w_ext;
    if (i_grant_q2) begin
      w_sum = w_ext - w_len;
    end else if (!i_q2_empty || r_credit[CREDIT_W-1]) begin
      w_sum = w_ext + w_slope;
    end else begin
      // empty with credit >= 0: positive credit clears, zero credit holds at 0
      w_sum = '0;
    end

    if (w_sum > W_MAX) begin
      w_next = CREDIT_MAX;
    end else if (w_sum < W_MIN) begin
      w_next = W_MIN[CREDIT_W-1:0];
    end else begin
      w_next = w_sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= '0;
    end else begin
      r_credit <= w_next;
    end
  end

  assign o_credit = r_credit;

endmodule

// File: rtl/gc_sched.sv
// Gate-control scheduler: drains four metadata queues toward the transmit
// scheduler with TSN slot parity gating, a q2 credit shaper and a guard band
// for q2/q3. One frame in flight until the transmitter reports completion.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       gc_sched_if.slave (queue flags, q2 length/slope, gate enable,
//             slot sync, tx done in; read pulses, parity, busy, credit,
//             timeout error out)
module gc_sched
  import gc_pkg::*;
#(
  parameter int unsigned                SLOT_CYCLES  = 1024,
  parameter int unsigned                GUARD_CYCLES = 128,
  parameter logic signed [CREDIT_W-1:0] CREDIT_MAX   = 20'sd65535,
  parameter int unsigned                TX_TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         rst,
  gc_sched_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned TO_W  = $clog2(TX_TIMEOUT);

  logic [CNT_W-1:0]           r_cnt;
  logic                       r_par;
  gc_state_e                  r_state;
  gc_state_e                  w_next;
  gc_qidx_t                   r_win;
  logic [LEN_W-1:0]           r_len;
  logic [TO_W-1:0]            r_to;
  logic                       r_err;
  logic [3:0]                 w_elig;
  logic                       w_guard_ok;
  logic                       w_any;
  logic                       w_to_exp;
  logic                       w_grant_q2;
  gc_qidx_t                   w_pick;
  logic signed [CREDIT_W-1:0] w_credit;

  // Slot counter: sync overrides the natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (bus.in_gc_slot_sync) begin
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (r_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
      r_cnt <= '0;
      r_par <= ~r_par;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // remaining >= GUARD  <=>  cnt <= SLOT-1-GUARD
  assign w_guard_ok = (r_cnt <= CNT_W'(SLOT_CYCLES - 1 - GUARD_CYCLES));

  assign w_elig[Q_TSN_EVEN] = !bus.in_gc_fifo_empty[Q_TSN_EVEN] && !r_par;
  assign w_elig[Q_TSN_ODD]  = !bus.in_gc_fifo_empty[Q_TSN_ODD]  &&  r_par;
  assign w_elig[Q_RSV]      = !bus.in_gc_fifo_empty[Q_RSV] && !w_credit[CREDIT_W-1] && w_guard_ok;
  assign w_elig[Q_BE]       = !bus.in_gc_fifo_empty[Q_BE] && w_guard_ok;

  assign w_any = bus.in_gc_gate_en && (|w_elig);

  always_comb begin
    w_pick = gc_qidx_t'(Q_BE);
    if (w_elig[Q_TSN_EVEN]) begin
      w_pick = gc_qidx_t'(Q_TSN_EVEN);
    end else if (w_elig[Q_TSN_ODD]) begin
      w_pick = gc_qidx_t'(Q_TSN_ODD);
    end else if (w_elig[Q_RSV]) begin
      w_pick = gc_qidx_t'(Q_RSV);
    end
  end

  assign w_to_exp = (r_state == WAIT) && !bus.in_gc_tx_done &&
                    (r_to == TO_W'(TX_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = GRANT;
      GRANT:   w_next = WAIT;
      WAIT:    if (bus.in_gc_tx_done || w_to_exp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
      r_len <= '0;
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_win <= w_pick;
        r_len <= bus.in_gc_pkt_len;
      end
      r_to <= (r_state == WAIT) ? r_to + 1'b1 : '0;
      if (w_to_exp) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_grant_q2 = (r_state == GRANT) && (r_win == gc_qidx_t'(Q_RSV));

  gc_cbs_credit #(
    .CREDIT_MAX (CREDIT_MAX)
  ) u_credit (
    .clk          (clk),
    .rst          (rst),
    .i_grant_q2   (w_grant_q2),
    .i_q2_empty   (bus.in_gc_fifo_empty[Q_RSV]),
    .i_pkt_len    (r_len),
    .i_idle_slope (bus.in_gc_idle_slope),
    .o_credit     (w_credit)
  );

  // Decoded from the state register so async reset drops them immediately.
  assign bus.out_gc_q_rden      = (r_state == GRANT) ? gc_onehot(r_win) : 4'b0000;
  assign bus.out_gc_busy        = (r_state != IDLE);
  assign bus.out_gc_slot_parity = r_par;
  assign bus.out_gc_credit      = w_credit;
  assign bus.out_gc_timeout_err = r_err;

endmodule

// File: tb/tb_gc_sched.sv
// Directed bench for gc_sched: reset, parity gating, priority, credit shaper,
// guard band, transmit timeout, async reset and slot sync.
module tb_gc_sched;

  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned n;
  int unsigned q0_cnt;
  int unsigned q1_cnt;
  logic prev_par;
  logic cur_par;

  // slot model
  logic [9:0] m_cnt;
  logic       m_par;

  gc_sched_if bus ();

  gc_sched #(
    .SLOT_CYCLES  (1024),
    .GUARD_CYCLES (128),
    .CREDIT_MAX   (20'sd65535),
    .TX_TIMEOUT   (4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0;
      m_par <= 1'b0;
    end else if (bus.in_gc_slot_sync) begin
      m_cnt <= '0;
      m_par <= 1'b0;
    end else if (m_cnt == 10'd1023) begin
      m_cnt <= '0;
      m_par <= ~m_par;
    end else begin
      m_cnt <= m_cnt + 10'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic signed [19:0] obs, input logic signed [19:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // prev_par = parity of the cycle whose closing edge made the latest decision
  task automatic step();
    prev_par = cur_par;
    @(negedge clk);
    cur_par = m_par;
  endtask

  task automatic wait_grant(output int unsigned cycles);
    cycles = 0;
    while (bus.out_gc_q_rden == 4'b0000 && cycles < 3000) begin
      step();
      cycles++;
    end
  endtask

  task automatic pulse_done();
    bus.in_gc_tx_done = 1'b1;
    step();
    bus.in_gc_tx_done = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.in_gc_slot_sync = 1'b1;
    step();
    bus.in_gc_slot_sync = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_par = 1'b0;
    cur_par  = 1'b0;
    rst = 1'b1;
    bus.in_gc_fifo_empty = 4'hF;
    bus.in_gc_pkt_len    = '0;
    bus.in_gc_idle_slope = '0;
    bus.in_gc_gate_en    = 1'b0;
    bus.in_gc_slot_sync  = 1'b0;
    bus.in_gc_tx_done    = 1'b0;
    repeat (3) step();

    // reset state
    chk("rst_rden", 32'(bus.out_gc_q_rden), 0);
    chk("rst_parity", 32'(bus.out_gc_slot_parity), 0);
    chk("rst_busy", 32'(bus.out_gc_busy), 0);
    chkc("rst_credit", bus.out_gc_credit, 20'sd0);
    chk("rst_err", 32'(bus.out_gc_timeout_err), 0);
    rst = 1'b0;
    step();

    // parity gating: q0 and q1 both pending, tx_done two cycles after grant
    bus.in_gc_gate_en    = 1'b1;
    bus.in_gc_fifo_empty = 4'b1100;
    q0_cnt = 0;
    q1_cnt = 0;
    n = 0;
    while (q1_cnt < 3 && n < 400) begin
      wait_grant(cyc);
      chk("par_rden", 32'(bus.out_gc_q_rden), prev_par ? 32'd2 : 32'd1);
      if (prev_par) q1_cnt++;
      else q0_cnt++;
      if (q1_cnt == 3) bus.in_gc_fifo_empty = 4'hF;
      step();
      step();
      pulse_done();
      n++;
    end
    chk("par_q1_grants", q1_cnt, 3);
    chk("par_q0_many", 32'(q0_cnt >= 200), 1);

    // priority q0 > q2 > q3, credit 0
    pulse_sync();
    chk("sync_parity", 32'(bus.out_gc_slot_parity), 0);
    bus.in_gc_idle_slope = 16'd0;
    bus.in_gc_pkt_len    = 11'd50;
    bus.in_gc_fifo_empty = 4'b0010;
    wait_grant(cyc);
    chk("prio_q0", 32'(bus.out_gc_q_rden), 32'b0001);
    bus.in_gc_fifo_empty = 4'b0011;
    step();
    chk("prio_q0_pulse1", 32'(bus.out_gc_q_rden), 0);
    pulse_done();
    wait_grant(cyc);
    chk("prio_q2", 32'(bus.out_gc_q_rden), 32'b0100);
    chk("prio_back2back", cyc, 1);
    bus.in_gc_fifo_empty = 4'b0111;
    step();
    chkc("prio_q2_debit", bus.out_gc_credit, -20'sd50);
    pulse_done();
    wait_grant(cyc);
    chk("prio_q3", 32'(bus.out_gc_q_rden), 32'b1000);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    pulse_done();
    bus.in_gc_idle_slope = 16'd50;
    step();
    chkc("prio_recover", bus.out_gc_credit, 20'sd0);
    step();
    chkc("prio_hold_zero", bus.out_gc_credit, 20'sd0);

    // credit shaper: len 100 debit, 25 cycles of recovery at slope 4
    pulse_sync();
    bus.in_gc_idle_slope = 16'd0;
    bus.in_gc_pkt_len    = 11'd100;
    bus.in_gc_fifo_empty = 4'b1011;
    wait_grant(cyc);
    chk("cbs_grant1", 32'(bus.out_gc_q_rden), 32'b0100);
    step();
    chkc("cbs_debit", bus.out_gc_credit, -20'sd100);
    bus.in_gc_idle_slope = 16'd4;
    pulse_done();
    repeat (23) step();
    chkc("cbs_rec24", bus.out_gc_credit, -20'sd4);
    chk("cbs_blocked24", 32'(bus.out_gc_q_rden), 0);
    step();
    chkc("cbs_rec25", bus.out_gc_credit, 20'sd0);
    chk("cbs_blocked25", 32'(bus.out_gc_q_rden), 0);
    step();
    chk("cbs_grant2", 32'(bus.out_gc_q_rden), 32'b0100);
    step();
    chkc("cbs_debit2", bus.out_gc_credit, -20'sd96);
    bus.in_gc_gate_en = 1'b0;
    pulse_done();
    repeat (39) step();
    chkc("cbs_accum", bus.out_gc_credit, 20'sd64);
    chk("cbs_gate_off", 32'(bus.out_gc_busy), 0);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    chkc("cbs_clear", bus.out_gc_credit, 20'sd0);
    bus.in_gc_fifo_empty = 4'b1011;
    bus.in_gc_idle_slope = 16'hFFFF;
    step();
    step();
    chkc("cbs_sat_max", bus.out_gc_credit, 20'sd65535);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    chkc("cbs_sat_clear", bus.out_gc_credit, 20'sd0);
    bus.in_gc_idle_slope = 16'd0;
    bus.in_gc_gate_en    = 1'b1;

    // guard band: q3 at cnt 900 waits for next slot, at cnt 895 goes
    pulse_sync();
    n = 0;
    while (m_cnt != 10'd900 && n < 2000) begin step(); n++; end
    bus.in_gc_fifo_empty = 4'b0111;
    n = 0;
    do begin
      step();
      n++;
      if (m_cnt != 10'd1) chk("guard_busy", 32'(bus.out_gc_busy), 0);
    end while (m_cnt != 10'd1 && n < 1100);
    chk("guard_next_slot", 32'(bus.out_gc_q_rden), 32'b1000);
    chk("guard_parity", 32'(bus.out_gc_slot_parity), 1);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    pulse_done();
    n = 0;
    while (m_cnt != 10'd895 && n < 2000) begin step(); n++; end
    bus.in_gc_fifo_empty = 4'b0111;
    step();
    chk("guard_895", 32'(bus.out_gc_q_rden), 32'b1000);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    pulse_done();

    // timeout after 4096 WAIT cycles
    pulse_sync();
    bus.in_gc_fifo_empty = 4'b0111;
    wait_grant(cyc);
    chk("to_grant", 32'(bus.out_gc_q_rden), 32'b1000);
    bus.in_gc_fifo_empty = 4'hF;
    repeat (4096) step();
    chk("to_last_wait_busy", 32'(bus.out_gc_busy), 1);
    chk("to_last_wait_err", 32'(bus.out_gc_timeout_err), 0);
    step();
    chk("to_idle", 32'(bus.out_gc_busy), 0);
    chk("to_err", 32'(bus.out_gc_timeout_err), 1);
    pulse_sync();
    bus.in_gc_fifo_empty = 4'b0111;
    wait_grant(cyc);
    chk("to_next_grant", 32'(bus.out_gc_q_rden), 32'b1000);
    bus.in_gc_fifo_empty = 4'hF;
    bus.in_gc_tx_done = 1'b1;
    step();
    bus.in_gc_tx_done = 1'b0;
    chk("done_in_grant_ignored", 32'(bus.out_gc_busy), 1);
    chk("to_err_sticky", 32'(bus.out_gc_timeout_err), 1);
    pulse_done();
    chk("done_in_wait", 32'(bus.out_gc_busy), 0);

    // async reset mid-WAIT of a q2 frame
    pulse_sync();
    bus.in_gc_pkt_len    = 11'd100;
    bus.in_gc_fifo_empty = 4'b1011;
    wait_grant(cyc);
    chk("rstw_grant", 32'(bus.out_gc_q_rden), 32'b0100);
    bus.in_gc_fifo_empty = 4'hF;
    step();
    chkc("rstw_credit_pre", bus.out_gc_credit, -20'sd100);
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy", 32'(bus.out_gc_busy), 0);
    chk("rstw_rden", 32'(bus.out_gc_q_rden), 0);
    chkc("rstw_credit", bus.out_gc_credit, 20'sd0);
    chk("rstw_err", 32'(bus.out_gc_timeout_err), 0);
    chk("rstw_parity", 32'(bus.out_gc_slot_parity), 0);
    step();
    step();
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("rstw_no_replay", 32'(bus.out_gc_busy), 0);
    end

    // counter restarted at 0: first wrap lands where the model says
    n = 0;
    while (!(m_cnt == 10'd1023 && !m_par) && n < 2000) begin step(); n++; end
    chk("ctr_before_wrap", 32'(bus.out_gc_slot_parity), 0);
    step();
    chk("ctr_after_wrap", 32'(bus.out_gc_slot_parity), 1);
    n = 0;
    while (m_cnt != 10'd500 && n < 2000) begin step(); n++; end
    chk("sync_odd_before", 32'(bus.out_gc_slot_parity), 1);
    pulse_sync();
    chk("sync_odd_parity", 32'(bus.out_gc_slot_parity), 0);
    repeat (1023) step();
    chk("sync_cnt0_before", 32'(bus.out_gc_slot_parity), 0);
    step();
    chk("sync_cnt0_wrap", 32'(bus.out_gc_slot_parity), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
